// File: rtl/demux_pkg.sv
// Shared constants for the stream demultiplexer family.
// Mode encodings and the helper that derives the channel-select width.
package demux_pkg;

  // Target selection modes driven on the 'mode' input.
  localparam logic MODE_ADDR = 1'b0;  // target comes from 'sel'
  localparam logic MODE_RR   = 1'b1;  // target comes from the round-robin pointer

  // Width of a channel index for 'ch' channels; never narrower than one bit.
  function automatic int sel_w_f(input int ch);
    if (ch <= 2) begin
      return 1;
    end
    return $clog2(ch);
  endfunction

endpackage : demux_pkg

// File: rtl/demux_chan_reg.sv
// Single-entry holding register for one demux output channel.
// A load always wins over a drain, so a word can be replaced in the same
// cycle the consumer takes the previous one without creating a bubble.
// The data register keeps its last value after a drain; only reset clears it.
module demux_chan_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Full/empty bit and payload: load sets full, drain without load clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule : demux_chan_reg

// File: rtl/stream_demux_n.sv
// Registered 1-to-CH stream demultiplexer (addressed or round-robin routing).
// Optional feature macro: DEMUX_BCAST_EN -- when defined, bcast=1 writes the
// input word into every channel at once; when undefined the bcast input is ignored.
//
// Handshake: a word moves on a rising edge exactly when valid & ready are both
// high in the preceding cycle. in_ready never looks at in_valid, and a channel
// counts as free when it is empty or its consumer takes the word this cycle.
module stream_demux_n
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 8,
  parameter int SEL_W = sel_w_f(CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic                bcast,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_data,
  output logic                in_ready,
  output logic [CH-1:0]       out_valid,
  output logic [CH*WIDTH-1:0] out_data,
  input  logic [CH-1:0]       out_ready,
  output logic [SEL_W-1:0]    rr_ptr,
  output logic                sel_err
);

  // One extra bit so CH itself is representable when CH is a power of two.
  localparam logic [SEL_W:0]   CH_EXT  = (SEL_W + 1)'(CH);
  localparam logic [SEL_W-1:0] RR_LAST = SEL_W'(CH - 1);

  logic [CH-1:0]    w_free;
  logic [CH-1:0]    w_load;
  logic [SEL_W-1:0] w_target;
  logic             w_target_ok;
  logic             w_free_t;
  logic             w_bcast;
  logic             w_in_ready;
  logic             w_accept;
  logic [SEL_W-1:0] r_rr_ptr;
  logic             r_sel_err;

`ifdef DEMUX_BCAST_EN
  assign w_bcast = bcast;
`else
  // Broadcast is compiled out; the port stays for a uniform interface.
  logic w_unused_bcast;
  assign w_unused_bcast = bcast;
  assign w_bcast        = 1'b0;
`endif

  // A channel can take a word if empty or being drained this cycle.
  assign w_free      = ~out_valid | out_ready;
  assign w_target    = (mode == MODE_RR) ? r_rr_ptr : sel;
  assign w_target_ok = ({1'b0, w_target} < CH_EXT);

  // Look up the free bit of the current target; out-of-range targets read as busy.
  always_comb begin
    w_free_t = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if (w_target == SEL_W'(k)) begin
        w_free_t = w_free[k];
      end
    end
  end

  // Input ready: broadcast needs every channel free, otherwise only the target.
  always_comb begin
    w_in_ready = 1'b0;
    if (w_bcast) begin
      w_in_ready = en & ~rst & (&w_free);
    end else begin
      w_in_ready = en & ~rst & w_target_ok & w_free_t;
    end
  end

  assign w_accept = in_valid & w_in_ready;

  // Per-channel load strobes: the decoded target, or all channels on broadcast.
  always_comb begin
    w_load = '0;
    for (int k = 0; k < CH; k++) begin
      w_load[k] = w_accept & (w_bcast | (w_target == SEL_W'(k)));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_chan
      demux_chan_reg #(
        .WIDTH (WIDTH)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[gi]),
        .i_data  (in_data),
        .i_ready (out_ready[gi]),
        .o_valid (out_valid[gi]),
        .o_data  (out_data[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // Round-robin pointer: moves only on a routed accept in RR mode, wraps at CH-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_accept && !w_bcast && (mode == MODE_RR)) begin
      r_rr_ptr <= (r_rr_ptr == RR_LAST) ? '0 : r_rr_ptr + 1'b1;
    end
  end

  // Select error: one-cycle pulse after an enabled addressed request to a missing channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= en & in_valid & (mode == MODE_ADDR) & ~w_bcast & ~w_target_ok;
    end
  end

  assign in_ready = w_in_ready;
  assign rr_ptr   = r_rr_ptr;
  assign sel_err  = r_sel_err;

endmodule : stream_demux_n

// File: tb/tb_stream_demux_n.sv
// Directed bench for stream_demux_n: an 8-channel instance driven from a
// vector table plus hand-written sequences, and a 6-channel instance for
// out-of-range select and non-power-of-two wrap.
module tb_stream_demux_n;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 8-channel instance
  logic        en8, mode8, bcast8, iv8, ir8, se8;
  logic [2:0]  sel8, rr8;
  logic [7:0]  id8, ov8, or8;
  logic [63:0] od8;

  // 6-channel instance
  logic        en6, mode6, bcast6, iv6, ir6, se6;
  logic [2:0]  sel6, rr6;
  logic [7:0]  id6;
  logic [5:0]  ov6, or6;
  logic [47:0] od6;

  stream_demux_n #(.WIDTH(8), .CH(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en8), .mode(mode8), .sel(sel8), .bcast(bcast8),
    .in_valid(iv8), .in_data(id8), .in_ready(ir8), .out_valid(ov8),
    .out_data(od8), .out_ready(or8), .rr_ptr(rr8), .sel_err(se8)
  );

  stream_demux_n #(.WIDTH(8), .CH(6)) u_dut6 (
    .clk(clk), .rst(rst), .en(en6), .mode(mode6), .sel(sel6), .bcast(bcast6),
    .in_valid(iv6), .in_data(id6), .in_ready(ir6), .out_valid(ov6),
    .out_data(od6), .out_ready(or6), .rr_ptr(rr6), .sel_err(se6)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ch8(input int k);
    logic [63:0] v;
    v = od8 >> (k * 8);
    return v[7:0];
  endfunction

  function automatic logic [7:0] ch6(input int k);
    logic [47:0] v;
    v = od6 >> (k * 8);
    return v[7:0];
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic       en;
    logic       mode;
    logic       vld;
    logic [2:0] sel;
    logic [7:0] data;
    logic [7:0] ordy;
    logic       e_rdy;
    logic [7:0] e_ov;
    int         e_ch;
    logic [7:0] e_dat;
    logic [2:0] e_rr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en, input logic mode, input logic vld,
                              input logic [2:0] sel, input logic [7:0] data,
                              input logic [7:0] ordy, input logic e_rdy,
                              input logic [7:0] e_ov, input int e_ch,
                              input logic [7:0] e_dat, input logic [2:0] e_rr);
    vec_t v;
    v.en = en; v.mode = mode; v.vld = vld; v.sel = sel; v.data = data; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_ch = e_ch; v.e_dat = e_dat; v.e_rr = e_rr;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Drive at the falling edge, check in_ready before the rising edge,
  // check registered outputs 1 time unit after it.
  task automatic apply8(input int idx, input vec_t v);
    @(negedge clk);
    en8 = v.en; mode8 = v.mode; iv8 = v.vld; sel8 = v.sel; id8 = v.data; or8 = v.ordy;
    #1;
    chk($sformatf("v%0d in_ready", idx), 64'(ir8), 64'(v.e_rdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", idx), 64'(ov8), 64'(v.e_ov));
    chk($sformatf("v%0d ch%0d data", idx, v.e_ch), 64'(ch8(v.e_ch)), 64'(v.e_dat));
    chk($sformatf("v%0d rr_ptr", idx), 64'(rr8), 64'(v.e_rr));
  endtask

  initial begin
    // 1..: fields en mode vld sel data ordy | rdy ov ch dat rr
    // addressed load + backpressure on ch5
    tbl.push_back(mk(1, 0, 1, 3'd5, 8'hA5, 8'h00, 1, 8'h20, 5, 8'hA5, 3'd0));
    tbl.push_back(mk(1, 0, 1, 3'd5, 8'h77, 8'h00, 0, 8'h20, 5, 8'hA5, 3'd0));
    tbl.push_back(mk(1, 0, 1, 3'd5, 8'h77, 8'h20, 1, 8'h20, 5, 8'h77, 3'd0));
    tbl.push_back(mk(1, 0, 0, 3'd5, 8'hEE, 8'h20, 1, 8'h00, 5, 8'h77, 3'd0));
    // drain+load on ch3
    tbl.push_back(mk(1, 0, 1, 3'd3, 8'h11, 8'h00, 1, 8'h08, 3, 8'h11, 3'd0));
    tbl.push_back(mk(1, 0, 1, 3'd3, 8'h3C, 8'h08, 1, 8'h08, 3, 8'h3C, 3'd0));
    tbl.push_back(mk(1, 0, 0, 3'd0, 8'h00, 8'hFF, 1, 8'h00, 3, 8'h3C, 3'd0));
    // global enable off: nothing accepted, pointer held
    tbl.push_back(mk(0, 1, 1, 3'd0, 8'h99, 8'hFF, 0, 8'h00, 0, 8'h00, 3'd0));
    // round-robin, ten words 10..19, consumers always ready
    tbl.push_back(mk(1, 1, 1, 3'd0, 8'h10, 8'hFF, 1, 8'h01, 0, 8'h10, 3'd1));
    tbl.push_back(mk(1, 1, 1, 3'd0, 8'h11, 8'hFF, 1, 8'h02, 1, 8'h11, 3'd2));
    tbl.push_back(mk(1, 1, 1, 3'd0, 8'h12, 8'hFF, 1, 8'h04, 2, 8'h12, 3'd3));
    tbl.push_back(mk(1, 1, 1, 3'd0, 8'h13, 8'hFF, 1, 8'h08, 3, 8'h13, 3'd4));
    tbl.push_back(mk(1, 1, 1, 3'd0, 8'h14, 8'hFF, 1, 8'h10, 4, 8'h14, 3'd5));
    tbl.push_back(mk(1, 1, 1, 3'd0, 8'h15, 8'hFF, 1, 8'h20, 5, 8'h15, 3'd6));
    tbl.push_back(mk(1, 1, 1, 3'd0, 8'h16, 8'hFF, 1, 8'h40, 6, 8'h16, 3'd7));
    tbl.push_back(mk(1, 1, 1, 3'd0, 8'h17, 8'hFF, 1, 8'h80, 7, 8'h17, 3'd0));
    tbl.push_back(mk(1, 1, 1, 3'd0, 8'h18, 8'hFF, 1, 8'h01, 0, 8'h18, 3'd1));
    tbl.push_back(mk(1, 1, 1, 3'd0, 8'h19, 8'hFF, 1, 8'h02, 1, 8'h19, 3'd2));
    // consumers stall: ch1 keeps its word, ch2 loads
    tbl.push_back(mk(1, 1, 1, 3'd0, 8'h20, 8'h00, 1, 8'h06, 2, 8'h20, 3'd3));
    // addressed write to ch3 leaves pointer alone
    tbl.push_back(mk(1, 0, 1, 3'd3, 8'h30, 8'h00, 1, 8'h0E, 3, 8'h30, 3'd3));
    // RR target ch3 busy: stall, pointer does not skip
    tbl.push_back(mk(1, 1, 1, 3'd0, 8'h31, 8'h00, 0, 8'h0E, 3, 8'h30, 3'd3));
    // ch3 drains and reloads in the same cycle
    tbl.push_back(mk(1, 1, 1, 3'd0, 8'h31, 8'h08, 1, 8'h0E, 3, 8'h31, 3'd4));
    // everything drains; ch0 still shows the wrapped word 18
    tbl.push_back(mk(1, 0, 0, 3'd0, 8'h00, 8'hFF, 1, 8'h00, 0, 8'h18, 3'd4));

    // ---------------- reset ----------------
    rst = 1'b1;
    en8 = 1; mode8 = 0; sel8 = 0; bcast8 = 0; iv8 = 1; id8 = 8'hFF; or8 = 8'h00;
    en6 = 1; mode6 = 0; sel6 = 0; bcast6 = 0; iv6 = 1; id6 = 8'hFF; or6 = 6'h00;
    @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 64'(ir8), 64'd0);
    chk("reset in_ready ch6", 64'(ir6), 64'd0);
    @(posedge clk);
    #1;
    chk("reset out_valid", 64'(ov8), 64'd0);
    chk("reset out_data", od8, 64'd0);
    chk("reset rr_ptr", 64'(rr8), 64'd0);
    chk("reset sel_err", 64'(se8), 64'd0);
    chk("reset out_valid ch6", 64'(ov6), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    iv8 = 0; en6 = 0; iv6 = 0;

    // ---------------- table ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      apply8(i, tbl[i]);
    end

    // ---------------- 6-channel: out-of-range select ----------------
    @(negedge clk);
    en6 = 1; mode6 = 0; sel6 = 3'd6; iv6 = 1; id6 = 8'h66; or6 = 6'h3F;
    #1;
    chk("ch6 sel6 in_ready", 64'(ir6), 64'd0);
    @(posedge clk);
    #1;
    chk("ch6 sel6 sel_err", 64'(se6), 64'd1);
    chk("ch6 sel6 out_valid", 64'(ov6), 64'd0);
    @(negedge clk);
    iv6 = 0;
    @(posedge clk);
    #1;
    chk("ch6 sel_err pulse end", 64'(se6), 64'd0);
    @(negedge clk);
    en6 = 0; iv6 = 1;
    @(posedge clk);
    #1;
    chk("ch6 en0 no sel_err", 64'(se6), 64'd0);
    @(negedge clk);
    en6 = 1; sel6 = 3'd5; id6 = 8'h55; or6 = 6'h00;
    #1;
    chk("ch6 sel5 in_ready", 64'(ir6), 64'd1);
    @(posedge clk);
    #1;
    chk("ch6 sel5 out_valid", 64'(ov6), 64'h20);
    chk("ch6 sel5 data", 64'(ch6(5)), 64'h55);
    chk("ch6 sel5 sel_err", 64'(se6), 64'd0);

    // ---------------- 6-channel: RR wrap at 5 -> 0 ----------------
    @(negedge clk);
    mode6 = 1; or6 = 6'h3F;
    for (int i = 0; i < 6; i++) begin
      id6 = 8'h60 + 8'(i);
      @(posedge clk);
      #1;
      chk($sformatf("ch6 rr step%0d rr_ptr", i), 64'(rr6), 64'((i + 1) % 6));
      chk($sformatf("ch6 rr step%0d data", i), 64'(ch6(i)), 64'(8'h60 + 8'(i)));
      @(negedge clk);
    end
    iv6 = 0;

    // ---------------- broadcast ----------------
    @(negedge clk);
    bcast8 = 1; en8 = 1; mode8 = 0; sel8 = 3'd1; iv8 = 1; id8 = 8'h5A; or8 = 8'hFF;
    #1;
    chk("bcast in_ready all free", 64'(ir8), 64'd1);
    @(posedge clk);
    #1;
`ifdef DEMUX_BCAST_EN
    chk("bcast out_valid", 64'(ov8), 64'hFF);
    chk("bcast out_data", od8, {8{8'h5A}});
    chk("bcast rr_ptr held", 64'(rr8), 64'd4);
    @(negedge clk);
    or8 = 8'hFE;
    #1;
    chk("bcast one busy in_ready", 64'(ir8), 64'd0);
    @(posedge clk);
    #1;
    chk("bcast sel_err", 64'(se8), 64'd0);
`else
    chk("bcast ignored out_valid", 64'(ov8), 64'h02);
    chk("bcast ignored ch1", 64'(ch8(1)), 64'h5A);
    chk("bcast ignored ch0", 64'(ch8(0)), 64'h18);
    @(negedge clk);
    or8 = 8'h00;
    #1;
    chk("bcast ignored busy in_ready", 64'(ir8), 64'd0);
    @(posedge clk);
    #1;
`endif

    // ---------------- reset mid-transfer ----------------
    @(negedge clk);
    bcast8 = 0; or8 = 8'h00; rst = 1'b1;
    #1;
    chk("mid reset in_ready", 64'(ir8), 64'd0);
    @(posedge clk);
    #1;
    chk("mid reset out_valid", 64'(ov8), 64'd0);
    chk("mid reset out_data", od8, 64'd0);
    chk("mid reset rr_ptr", 64'(rr8), 64'd0);
    chk("mid reset rr_ptr ch6", 64'(rr6), 64'd0);
    @(negedge clk);
    rst = 1'b0; iv8 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_stream_demux_n
